// File: rtl/nrisc_pkg.sv
// rtl/nrisc_pkg.sv - shared NRISC types and widths for the data-memory responder
// Purpose: word/address widths, FSM state encoding and access-operation type.
// Ports: none (package).
package nrisc_pkg;

  localparam int NRISC_WORD_W = 16;
  localparam int NRISC_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_STORE = 2'd1,
    OP_LOAD  = 2'd2
  } op_e;

  // Store outranks load when the CPU raises both.
  function automatic op_e decode_op(input logic write, input logic load);
    if (write)     return OP_STORE;
    else if (load) return OP_LOAD;
    else           return OP_NONE;
  endfunction

endpackage

// File: rtl/nrisc_data_mem_if.sv
// rtl/nrisc_data_mem_if.sv - CPU DATA bus bundle between control unit and data memory
// Purpose: groups the request, data and status signals of the DATA bus.
// Ports (master drives): DATA_ADDR_clk, DATA_write, DATA_load, DATA_ADDR, DATA_in, DATA_err_clr
//       (slave drives) : DATA_out, DATA_ready, DATA_busy, DATA_err
interface nrisc_data_mem_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              DATA_ADDR_clk;
  logic              DATA_write;
  logic              DATA_load;
  logic [ADDR_W-1:0] DATA_ADDR;
  logic [DATA_W-1:0] DATA_in;
  logic              DATA_err_clr;
  logic [DATA_W-1:0] DATA_out;
  logic              DATA_ready;
  logic              DATA_busy;
  logic              DATA_err;

  modport master (
    output DATA_ADDR_clk, DATA_write, DATA_load, DATA_ADDR, DATA_in, DATA_err_clr,
    input  DATA_out, DATA_ready, DATA_busy, DATA_err
  );

  modport slave (
    input  DATA_ADDR_clk, DATA_write, DATA_load, DATA_ADDR, DATA_in, DATA_err_clr,
    output DATA_out, DATA_ready, DATA_busy, DATA_err
  );
endinterface

// File: rtl/nrisc_data_ram.sv
// rtl/nrisc_data_ram.sv - single-port synchronous word array
// Purpose: DEPTH x DATA_W storage, write on we, registered read of addr (one-cycle latency).
// Ports: clk, we (write enable), addr (word index), wdata (write word), rdata (registered read word).
// Contents are deliberately not reset so they survive a CPU reset.
module nrisc_data_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end
endmodule

// File: rtl/nrisc_data_mem.sv
// rtl/nrisc_data_mem.sv - NRISC DATA-bus memory responder with configurable wait states
// Purpose: accepts load/store requests on the strobe, waits WAIT_CYCLES, performs the
//          access on nrisc_data_ram and returns data with a one-cycle ready pulse.
// Ports: clk (posedge), rst (async active-low), bus (nrisc_data_mem_if.slave):
//        request strobe/write/load/address/data/err-clear in; data, ready, busy, sticky err out.
module nrisc_data_mem
  import nrisc_pkg::*;
#(
  parameter int ADDR_W      = NRISC_ADDR_W,
  parameter int DATA_W      = NRISC_WORD_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  nrisc_data_mem_if.slave   bus
);
  localparam int              RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic              in_range;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  // Full-width unsigned compare: high address bits are never aliased onto the array.
  assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
  assign ram_we   = (state_q == ACCESS) && (op_q == OP_STORE) && in_range;

  // The RAM read is registered, so the address is presented one edge ahead of the
  // access edge: in IDLE the incoming request address (covers WAIT_CYCLES=0), later
  // the latched one. By the access edge ram_rdata already holds mem[addr_q].
  assign ram_addr = (state_q == IDLE) ? bus.DATA_ADDR[RAM_AW-1:0] : addr_q[RAM_AW-1:0];

  nrisc_data_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    out_d   = out_q;
    ready_d = 1'b0;
    err_d   = bus.DATA_err_clr ? 1'b0 : err_q;

    case (state_q)
      IDLE: begin
        if (bus.DATA_ADDR_clk) begin
          addr_d  = bus.DATA_ADDR;
          wdata_d = bus.DATA_in;
          op_d    = decode_op(bus.DATA_write, bus.DATA_load);
          if (op_d != OP_NONE) begin
            if (WAIT_CYCLES == 0) begin
              state_d = ACCESS;
            end else begin
              state_d = WAIT;
              cnt_d   = WAIT_INIT;
            end
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ready_d = 1'b1;
        state_d = IDLE;
        if (!in_range) begin
          err_d = 1'b1;  // set outranks a simultaneous clear
        end
        if (op_q == OP_LOAD) begin
          out_d = in_range ? ram_rdata : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.DATA_out   = out_q;
  assign bus.DATA_ready = ready_q;
  assign bus.DATA_busy  = (state_q != IDLE);
  assign bus.DATA_err   = err_q;

endmodule

// File: tb/tb_nrisc_data_mem.sv
// tb/tb_nrisc_data_mem.sv - randomized self-checking bench for nrisc_data_mem (WAIT_CYCLES 0, 1, 3)
module tb_nrisc_data_mem;
  localparam int NI = 3;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        s_strobe = 1'b0, s_wr = 1'b0, s_ld = 1'b0, s_clr = 1'b0;
  logic [15:0] s_addr = '0, s_din = '0;

  nrisc_data_mem_if #(.ADDR_W(16), .DATA_W(16)) if0 ();
  nrisc_data_mem_if #(.ADDR_W(16), .DATA_W(16)) if1 ();
  nrisc_data_mem_if #(.ADDR_W(16), .DATA_W(16)) if3 ();

  assign if0.DATA_ADDR_clk = s_strobe; assign if1.DATA_ADDR_clk = s_strobe; assign if3.DATA_ADDR_clk = s_strobe;
  assign if0.DATA_write    = s_wr;     assign if1.DATA_write    = s_wr;     assign if3.DATA_write    = s_wr;
  assign if0.DATA_load     = s_ld;     assign if1.DATA_load     = s_ld;     assign if3.DATA_load     = s_ld;
  assign if0.DATA_ADDR     = s_addr;   assign if1.DATA_ADDR     = s_addr;   assign if3.DATA_ADDR     = s_addr;
  assign if0.DATA_in       = s_din;    assign if1.DATA_in       = s_din;    assign if3.DATA_in       = s_din;
  assign if0.DATA_err_clr  = s_clr;    assign if1.DATA_err_clr  = s_clr;    assign if3.DATA_err_clr  = s_clr;

  nrisc_data_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  nrisc_data_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  nrisc_data_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  logic [15:0] o_out  [NI];
  logic        o_rdy  [NI];
  logic        o_busy [NI];
  logic        o_err  [NI];
  assign o_out[0] = if0.DATA_out;   assign o_out[1] = if1.DATA_out;   assign o_out[2] = if3.DATA_out;
  assign o_rdy[0] = if0.DATA_ready; assign o_rdy[1] = if1.DATA_ready; assign o_rdy[2] = if3.DATA_ready;
  assign o_busy[0] = if0.DATA_busy; assign o_busy[1] = if1.DATA_busy; assign o_busy[2] = if3.DATA_busy;
  assign o_err[0] = if0.DATA_err;   assign o_err[1] = if1.DATA_err;   assign o_err[2] = if3.DATA_err;

  // Transaction-level reference: an accepted request completes WAIT_CYCLES+1 edges later.
  int          wc     [NI] = '{0, 1, 3};
  logic [15:0] mem_m  [NI][DEPTH];
  bit          mem_k  [NI][DEPTH];
  bit          busy_m [NI];
  int          left_m [NI];
  bit          wr_m   [NI];
  logic [15:0] a_m    [NI];
  logic [15:0] d_m    [NI];
  logic [15:0] out_m  [NI];
  bit          out_k  [NI];
  bit          rdy_m  [NI];
  bit          err_m  [NI];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      busy_m[k] = 0; left_m[k] = 0; rdy_m[k] = 0; err_m[k] = 0;
      out_m[k] = '0; out_k[k] = 1;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      bit set_err;
      set_err  = 0;
      rdy_m[k] = 0;
      if (busy_m[k]) begin
        left_m[k]--;
        if (left_m[k] == 0) begin
          busy_m[k] = 0;
          rdy_m[k]  = 1;
          if (int'(a_m[k]) >= DEPTH) begin
            set_err = 1;
            if (!wr_m[k]) begin out_m[k] = '0; out_k[k] = 1; end
          end else if (wr_m[k]) begin
            mem_m[k][a_m[k]] = d_m[k];
            mem_k[k][a_m[k]] = 1;
          end else begin
            out_m[k] = mem_m[k][a_m[k]];
            out_k[k] = mem_k[k][a_m[k]];
          end
        end
      end else if (s_strobe && (s_wr || s_ld)) begin
        busy_m[k] = 1;
        left_m[k] = wc[k] + 1;
        wr_m[k]   = s_wr;
        a_m[k]    = s_addr;
        d_m[k]    = s_din;
      end
      if (set_err)    err_m[k] = 1;
      else if (s_clr) err_m[k] = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("busy_w%0d", wc[k]),  32'(o_busy[k]), 32'(busy_m[k]));
      check($sformatf("ready_w%0d", wc[k]), 32'(o_rdy[k]),  32'(rdy_m[k]));
      check($sformatf("err_w%0d", wc[k]),   32'(o_err[k]),  32'(err_m[k]));
      if (out_k[k]) check($sformatf("out_w%0d", wc[k]), 32'(o_out[k]), 32'(out_m[k]));
    end
  endtask

  task automatic cyc(input bit st, input bit wr, input bit ld,
                     input logic [15:0] a, input logic [15:0] d, input bit clr);
    s_strobe = st; s_wr = wr; s_ld = ld; s_addr = a; s_din = d; s_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 16'h0, 16'h0, 0);
  endtask

  // Reset asserted mid-cycle: outputs must drop without waiting for a clock edge.
  task automatic pulse_reset();
    s_strobe = 0; s_wr = 0; s_ld = 0; s_clr = 0;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < NI; k++)
      for (int j = 0; j < DEPTH; j++) begin mem_k[k][j] = 0; mem_m[k][j] = '0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    idle(2);

    // Store then load back, basic latency.
    cyc(1, 1, 0, 16'h0012, 16'hBEEF, 0); idle(5);
    cyc(1, 0, 1, 16'h0012, 16'h0000, 0); idle(5);
    check("load_beef_w1", 32'(o_out[1]), 32'hBEEF);
    cyc(1, 1, 0, 16'h0001, 16'h1234, 0); idle(5);
    cyc(1, 0, 1, 16'h0001, 16'h0000, 0); idle(5);
    check("load_1234_w0", 32'(o_out[0]), 32'h1234);

    // Out of range: no write, zero data, sticky error, clear, set-beats-clear.
    cyc(1, 1, 0, 16'h0100, 16'h5555, 0); idle(5);
    check("oor_err_w3", 32'(o_err[2]), 32'h1);
    cyc(1, 0, 1, 16'h0100, 16'h0000, 0); idle(5);
    check("oor_out_w1", 32'(o_out[1]), 32'h0);
    cyc(0, 0, 0, 16'h0, 16'h0, 1);
    check("err_clr_w1", 32'(o_err[1]), 32'h0);
    cyc(1, 1, 0, 16'h0100, 16'h5555, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 16'h0, 16'h0, 1);
    idle(2);

    // Back-to-back strobes while busy, including strobes in the ready cycle.
    for (int i = 0; i < 12; i++) cyc(1, 0, 1, 16'h0012, 16'h0000, 0);
    idle(5);

    // Reset during the wait: aborted store, storage retained.
    cyc(1, 1, 0, 16'h0012, 16'hAAAA, 0);
    pulse_reset();
    idle(1);
    cyc(1, 0, 1, 16'h0012, 16'h0000, 0); idle(5);
    check("abort_kept_w1", 32'(o_out[1]), 32'hBEEF);
    check("abort_kept_w3", 32'(o_out[2]), 32'hBEEF);

    // Address-only latch, and write+load priority.
    cyc(1, 0, 0, 16'h0003, 16'h9999, 0); idle(3);
    cyc(1, 1, 1, 16'h0003, 16'h7777, 0); idle(5);
    cyc(1, 0, 1, 16'h0003, 16'h0000, 0); idle(5);
    check("wr_prio_w0", 32'(o_out[0]), 32'h7777);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 7))
        0:       a = 16'h0100 + 16'($urandom_range(0, 3));
        1:       a = 16'hFFFF;
        2:       a = 16'h00FF;
        default: a = 16'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        cyc($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            a, 16'($urandom), $urandom_range(0, 7) == 0);
      end
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/nrisc_data_mem.md
Name: nrisc_data_mem

Overview:
Data-memory responder for the NRISC CPU's DATA bus. It receives the address latch strobe, load and store controls, address and write data issued by the CPU control unit, and performs the access on internal word storage. It inserts a configurable number of wait states, then returns read data together with a one-cycle ready pulse. It sits between the ULA address output, the register-file write-data path, and the DATA→REG mux.

Parameters:
ADDR_W, 16, address width (ULA output width)
DATA_W, 16, word width
DEPTH, 256, number of implemented words; valid addresses are 0..DEPTH-1
WAIT_CYCLES, 1, wait states inserted before the access; legal range 0..15

Ports:
clk  in  1  main clock; all logic on posedge
rst  in  1  reset, asynchronous, active-low
DATA_ADDR_clk  in  1  request strobe; sampled high at posedge = new request
DATA_write  in  1  store request; sampled with the strobe
DATA_load  in  1  load request; sampled with the strobe
DATA_ADDR  in  ADDR_W  access address (from ULA)
DATA_in  in  DATA_W  store data (from REG RF2 path)
DATA_err_clr  in  1  clears the sticky error flag
DATA_out  out  DATA_W  read data; held until the next completed load
DATA_ready  out  1  one-cycle completion pulse
DATA_busy  out  1  high while a request is in flight
DATA_err  out  1  sticky out-of-range flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0
  - DATA_out=0, DATA_ready=0, DATA_busy=0, DATA_err=0
  - storage contents are not reset and are retained across reset
- Request acceptance: only in IDLE, at a posedge with DATA_ADDR_clk=1.
  - Latch DATA_ADDR, DATA_in and the operation.
  - Operation priority: DATA_write=1 → STORE; else DATA_load=1 → LOAD; else address-only latch (no access, no busy, no ready).
  - Strobes seen while not in IDLE are ignored: no latch, no flag.
- States:
  - IDLE (busy=0): on STORE/LOAD, go to WAIT with cnt=WAIT_CYCLES; if WAIT_CYCLES=0, go directly to ACCESS.
  - WAIT (busy=1): cnt decrements each edge; at the edge where cnt==1, go to ACCESS.
  - ACCESS (busy=1): on the next edge, perform the operation, set DATA_ready=1 and go to IDLE.
- Latency:
  - Request edge E0; DATA_ready is high for exactly one cycle after edge E0+WAIT_CYCLES+1.
  - DATA_busy is high from after E0 until that same edge.
  - Earliest next request is accepted at edge E0+WAIT_CYCLES+2 (the ready cycle itself is IDLE, so a strobe there is accepted).
- STORE: mem[addr_q] ← data_q at the ACCESS edge.
- LOAD: DATA_out ← mem[addr_q] at the ACCESS edge (registered; valid together with DATA_ready).
- Out of range (addr_q ≥ DEPTH):
  - no write
  - LOAD returns DATA_out=0
  - DATA_err set at the ACCESS edge
  - DATA_ready still pulses
- DATA_err:
  - sticky; cleared by DATA_err_clr=1 at a posedge
  - set wins over a simultaneous clear
- Reset mid-operation: the in-flight access is aborted (no write occurs), and the block returns to IDLE with reset output values.
- Address arithmetic is an unsigned compare; no wrap-around. High address bits above log2(DEPTH) are not aliased.

Decomposition:
- Shared package nrisc_pkg:
  - state enum {IDLE, WAIT, ACCESS}
  - NRISC_WORD_W=16
  - NRISC_ADDR_W=16
- One sub-module, nrisc_data_ram: single-port synchronous word array with ports we, addr, wdata, rdata, one-cycle read.
- The FSM, wait counter, request latches and error logic stay in nrisc_data_mem.

Test Plan:
1. WAIT_CYCLES=1: strobe+write, addr 0x0012, DATA_in 0xBEEF at E0 → busy high for cycles E0..E2, ready pulse after E2. Then strobe+load at 0x0012 → DATA_out=0xBEEF with ready, two edges after that request.
2. WAIT_CYCLES=0: store 0x1234 at 0x0001, then load 0x0001 → ready one edge after each request, DATA_out=0x1234.
3. Store 0x5555 to 0x0100 (DEPTH=256) → no write, ready pulses, DATA_err=1. Load 0x0100 → DATA_out=0x0000. DATA_err_clr → DATA_err=0. A clear on the same edge as a new error → DATA_err stays 1.
4. Load at 0x0012 at E0, second strobe+load at E1 while busy → exactly one ready pulse; a strobe in the ready cycle is accepted with normal latency.
5. Store 0xAAAA to 0x0012 at E0, rst low during WAIT → busy=0, ready=0, DATA_out=0 immediately. After reset release, load 0x0012 → 0xBEEF (abort honoured, storage retained).
6. Strobe with DATA_write=DATA_load=0 → busy and ready stay 0. Strobe with both write and load high → STORE performed.
